hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO width (even, >= 4).
REQ-002 The block SHALL take parameter SIGNED_DIV_OVF_SAT, default 0: 0 = wrap, 1 = saturate the most-negative/-1 quotient.
REQ-003 Port Clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port Reset, input, 1: reset, asynchronous and active-low.
REQ-005 Port Start, input, 1: request; sampled only while Busy=0.
REQ-006 Port Op, input, 3: operation code (package encoding).
REQ-007 Port OperandA, input, WIDTH: rs value (dividend / multiplicand / MTHI/MTLO source).
REQ-008 Port OperandB, input, WIDTH: rt value (divisor / multiplier).
REQ-009 Port Flush, input, 1: abort the in-flight operation (branch/jump squash).
REQ-010 Port Busy, output, 1: operation in flight; the pipeline stalls ID/EX while high.
REQ-011 Port Done, output, 1: one-cycle pulse, coincident with the first cycle new HI/LO are visible.
REQ-012 Port DivByZero, output, 1: valid with Done; high when a DIV/DIVU had OperandB=0.
REQ-013 Port HI, output, WIDTH: architectural HI register.
REQ-014 Port LO, output, WIDTH: architectural LO register.

Function
REQ-015 Op encodings SHALL be MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7.
REQ-016 The FSM SHALL have states IDLE, CALC and FIX; Busy=1 exactly in CALC and FIX.
REQ-017 In IDLE, Start with Op 0-5 SHALL latch operand magnitudes and sign flags, load the counter with WIDTH and enter CALC.
REQ-018 In IDLE, Start with MTHI/MTLO SHALL write OperandA into HI/LO at that edge, leave Busy=0 and pulse Done the next cycle.
REQ-019 CALC SHALL process one bit per cycle: shift-add for multiply, restoring for divide; it lasts exactly WIDTH cycles, then enters FIX.
REQ-020 FIX SHALL last one cycle: apply the sign correction, accumulate for MADD/MSUB, write HI/LO, return to IDLE and set Done for the next cycle.
REQ-021 Latency SHALL be fixed: Start sampled at edge k gives Done=1 and Busy=0 in the cycle after edge k+WIDTH+1 (cycle 34 for WIDTH=32).
REQ-022 Multiply SHALL yield {HI,LO} = the 2*WIDTH-bit product; MULT is signed, MULTU unsigned.
REQ-023 MADD/MSUB SHALL yield {HI,LO} = {HI,LO} +/- the signed product, modulo 2^(2*WIDTH).
REQ-024 Divide SHALL yield LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-025 Divide-by-zero SHALL yield HI = OperandA, LO = all ones, DivByZero=1, with normal latency.
REQ-026 For DIV of the most-negative value by -1, LO SHALL be the most-negative value (wrap) or the most-positive value (saturate), and HI=0.
REQ-027 Start while Busy=1 SHALL be ignored; Start in the Done cycle SHALL be accepted.
REQ-028 Flush in CALC or FIX SHALL return the FSM to IDLE at the next edge; HI/LO are unchanged, no Done, Busy=0 next cycle.
REQ-029 Flush and Start in the same IDLE cycle SHALL give Flush priority: the request is dropped.
REQ-030 HI/LO SHALL change only at MTHI/MTLO acceptance or FIX completion.

Reset
REQ-031 Reset low SHALL immediately force IDLE, with Busy=0, Done=0, DivByZero=0, HI=0, LO=0 and counter=0, including mid-operation.
REQ-032 After reset release, the first Start SHALL be accepted on the first rising edge.

Structure
REQ-033 Package hilo_muldiv_pkg SHALL hold the Op encodings, the FSM state encoding and the opcode-class helpers (is_mul, is_div, is_signed).
REQ-034 The sign correction and MADD/MSUB accumulation SHALL be a combinational sub-module, muldiv_fixup; everything else SHALL be in hilo_muldiv.

Verification
REQ-035 MULT with A=0xFFFFFFFD (-3), B=7 SHALL give Done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 DIV with A=0xFFFFFFF9 (-7), B=2 SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=100, B=0 SHALL give HI=100, LO=0xFFFFFFFF, DivByZero=1.
REQ-037 MTLO with A=0xFFFFFFFF, then MTHI with A=0, then MADD with A=1, B=1 SHALL give HI=1, LO=0.
REQ-038 MULTU with A=B=0xFFFFFFFF SHALL give HI=0xFFFFFFFE, LO=1; a Start issued at cycle 5 of that operation SHALL be ignored.
REQ-039 Flush at cycle 10 of a DIV SHALL give Busy=0 at cycle 11, HI/LO unchanged and no Done pulse.
REQ-040 Reset asserted mid-CALC SHALL clear all outputs at once; a MULT 6*7 after release SHALL give LO=42, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared opcode encodings, FSM state encoding and opcode-class helpers
// for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // MADD/MSUB accumulate a signed product, so they count as signed ops.
  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_fixup.sv
// Combinational result stage: turns the unsigned magnitude result of the
// iterative datapath into the final HI/LO pair (signs, accumulate, div-by-zero).
module muldiv_fixup
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH              = 32,
  parameter int SIGNED_DIV_OVF_SAT = 0
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   hiIn,
  input  logic [WIDTH-1:0]   loIn,
  output logic [WIDTH-1:0]   hiOut,
  output logic [WIDTH-1:0]   loOut
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic               negA;
  logic               negB;
  logic [2*WIDTH-1:0] prodSigned;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    negA       = is_signed(op) && opA[WIDTH-1];
    negB       = is_signed(op) && opB[WIDTH-1];
    prodSigned = (negA ^ negB) ? -prod : prod;
    acc        = {hiIn, loIn};
    quo        = prod[WIDTH-1:0];
    rem        = prod[2*WIDTH-1:WIDTH];
    result     = prodSigned;

    case (op)
      OP_MADD: result = acc + prodSigned;
      OP_MSUB: result = acc - prodSigned;
      OP_DIV, OP_DIVU: begin
        if (opB == '0) begin
          result = {opA, {WIDTH{1'b1}}};
        end else begin
          if (negA ^ negB) quo = -quo;
          if (negA) rem = -rem;
          // Most-negative / -1 wraps back to most-negative unless saturating.
          if ((SIGNED_DIV_OVF_SAT != 0) && (op == OP_DIV) &&
              (opA == MOST_NEG) && (opB == {WIDTH{1'b1}}))
            quo = MOST_POS;
          result = {rem, quo};
        end
      end
      default: result = prodSigned;
    endcase

    hiOut = result[2*WIDTH-1:WIDTH];
    loOut = result[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle in CALC,
// sign correction and accumulation in a single FIX cycle.
//   state   | meaning
//   IDLE    | waiting for Start; MTHI/MTLO complete here
//   CALC    | WIDTH cycles of shift-add (mul) or restoring (div) steps
//   FIX     | sign fixup / accumulate, HI/LO written at exit
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH              = 32,
  parameter int SIGNED_DIV_OVF_SAT = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         opReg;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] prodStep;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  assign Busy = (state != ST_IDLE);

  always_comb begin
    magA = (is_signed(Op) && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    magB = (is_signed(Op) && OperandB[WIDTH-1]) ? -OperandB : OperandB;
  end

  // prod holds {partial, multiplier} for mul and {remainder, quotient} for div;
  // addend is the multiplicand or divisor magnitude respectively.
  always_comb begin
    mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? addend : {WIDTH{1'b0}})};
    divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    divTrial = divShift - {1'b0, addend};
    if (is_div(opReg)) begin
      if (divTrial[WIDTH])
        prodStep = {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else
        prodStep = {divTrial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end else begin
      prodStep = {mulSum, prod[WIDTH-1:1]};
    end
  end

  muldiv_fixup #(
    .WIDTH              (WIDTH),
    .SIGNED_DIV_OVF_SAT (SIGNED_DIV_OVF_SAT)
  ) uFixup (
    .op    (opReg),
    .opA   (opA),
    .opB   (opB),
    .prod  (prod),
    .hiIn  (HI),
    .loIn  (LO),
    .hiOut (fixHi),
    .loOut (fixLo)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      opReg     <= OP_MULT;
      opA       <= '0;
      opB       <= '0;
      addend    <= '0;
      prod      <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Flush) begin
            if (Op == OP_MTHI) begin
              HI   <= OperandA;
              Done <= 1'b1;
            end else if (Op == OP_MTLO) begin
              LO   <= OperandA;
              Done <= 1'b1;
            end else begin
              opReg  <= Op;
              opA    <= OperandA;
              opB    <= OperandB;
              addend <= is_div(Op) ? magB : magA;
              prod   <= {{WIDTH{1'b0}}, (is_div(Op) ? magA : magB)};
              cnt    <= CW'(WIDTH);
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (Flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            prod <= prodStep;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!Flush) begin
            HI        <= fixHi;
            LO        <= fixLo;
            Done      <= 1'b1;
            DivByZero <= is_div(opReg) && (opB == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, hand-written
// corner sequences, then random ops against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         Flush = 1'b0;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  hilo_muldiv #(.WIDTH(W), .SIGNED_DIV_OVF_SAT(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    logic         expDbz;
  } vec_t;

  vec_t vecs[11];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] hiM = '0;
  logic [W-1:0] loM = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic modelApply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic expDbz);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {hiM, loM};
    expDbz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; {hiM, loM} = p; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {hiM, loM} = p; end
      OP_MADD:  begin p = acc + (sa * sb); {hiM, loM} = p; end
      OP_MSUB:  begin p = acc - (sa * sb); {hiM, loM} = p; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          hiM = a; loM = '1; expDbz = 1'b1;
        end else begin
          if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
          else begin q = longint'({32'b0, a}) / longint'({32'b0, b});
                     r = longint'({32'b0, a}) % longint'({32'b0, b}); end
          p = q; loM = p[31:0];
          p = r; hiM = p[31:0];
        end
      end
      OP_MTHI: hiM = a;
      default: loM = a;
    endcase
  endtask

  // lat = edges after the sampling edge until Done seen (0 = Done right after it).
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inj, output int lat);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      if (inj > 0 && lat == inj) begin
        Start = 1'b1; Op = OP_MTHI; OperandA = 32'h1234_5678;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      lat++;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int inj,
                             input logic [W-1:0] eHi, input logic [W-1:0] eLo, input logic eDbz);
    int lat;
    runOp(op, a, b, inj, lat);
    check({name, " latency"}, 64'(lat), (op == OP_MTHI || op == OP_MTLO) ? 64'd0 : 64'(W + 1));
    check({name, " hi"}, 64'(HI), 64'(eHi));
    check({name, " lo"}, 64'(LO), 64'(eLo));
    check({name, " dbz"}, 64'(DivByZero), 64'(eDbz));
    check({name, " busy"}, 64'(Busy), 64'd0);
  endtask

  function automatic logic [W-1:0] pickVal();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic dbz;
    logic [W-1:0] hiSave, loSave;
    int doneSeen;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2]  = '{OP_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{OP_MTLO,  32'hFFFF_FFFF, 32'd0,        32'd100,       32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{OP_MTHI,  32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{OP_MADD,  32'd1,         32'd1,        32'd1,         32'd0,         1'b0};
    vecs[6]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        1'b0};
    vecs[7]  = '{OP_MSUB,  32'd2,         32'd3,        32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0};

    repeat (3) @(posedge Clk);
    #1;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    check("reset hi", 64'(HI), 64'd0);
    check("reset lo", 64'(LO), 64'd0);
    Reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      modelApply(vecs[i].op, vecs[i].a, vecs[i].b, dbz);
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
                  vecs[i].expHi, vecs[i].expLo, vecs[i].expDbz);
    end

    // Start arriving mid-operation must be ignored.
    modelApply(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dbz);
    runAndCheck("busy start ignored", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                32'hFFFF_FFFE, 32'd1, 1'b0);

    // Flush of a DIV in CALC.
    hiSave = HI; loSave = LO;
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIV; OperandA = 32'd1000; OperandB = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    check("flush calc busy before", 64'(Busy), 64'd1);
    @(negedge Clk); Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush calc busy after", 64'(Busy), 64'd0);
    doneSeen = 0;
    repeat (W + 5) begin
      @(posedge Clk); #1;
      if (Done) doneSeen++;
    end
    check("flush calc no done", 64'(doneSeen), 64'd0);
    check("flush calc hi", 64'(HI), 64'(hiSave));
    check("flush calc lo", 64'(LO), 64'(loSave));

    // Flush landing in the FIX cycle.
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULT; OperandA = 32'd5; OperandB = 32'd9;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (W) @(posedge Clk);
    #1;
    check("flush fix busy before", 64'(Busy), 64'd1);
    @(negedge Clk); Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush fix busy", 64'(Busy), 64'd0);
    check("flush fix done", 64'(Done), 64'd0);
    check("flush fix hi", 64'(HI), 64'(hiSave));
    check("flush fix lo", 64'(LO), 64'(loSave));

    // Flush and Start together in IDLE: request dropped.
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1; Op = OP_MTHI; OperandA = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("idle flush busy", 64'(Busy), 64'd0);
    check("idle flush done", 64'(Done), 64'd0);
    check("idle flush hi", 64'(HI), 64'(hiSave));

    // Random ops against the model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pickVal();
      b = pickVal();
      modelApply(op, a, b, dbz);
      runAndCheck($sformatf("rand%0d op%0d", i, op), op, a, b, 0, hiM, loM, dbz);
    end

    // Asynchronous reset mid-CALC.
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIV; OperandA = 32'hFFFF_0000; OperandB = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("async reset busy", 64'(Busy), 64'd0);
    check("async reset done", 64'(Done), 64'd0);
    check("async reset dbz", 64'(DivByZero), 64'd0);
    check("async reset hilo", {HI, LO}, 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    hiM = '0; loM = '0;
    modelApply(OP_MULT, 32'd6, 32'd7, dbz);
    runAndCheck("mult after reset", OP_MULT, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
